wr_level_mon: RTL

Write-domain occupancy monitor for the async FIFO, sitting directly downstream of the write-pointer handler. It consumes the binary write pointer, the synchronized Gray read pointer and the registered full flag. From these it produces a registered fill level, a programmable almost-full flag, a high-water mark, and overflow diagnostics (writes attempted while full). All logic is in the write clock domain; no CDC logic lives here.

---
 rtl/wr_level_mon.sv | 106 ++++++++++
 1 files changed

// File: rtl/wr_level_mon.sv
// Write-domain FIFO occupancy monitor: fill level, almost-full, high-water mark, overflow stats.
// Level path is two registered stages (inputs -> wlevel in 2 edges); no backpressure, observe-only.
module wr_level_mon #(
    parameter int PTR_WIDTH = 3,
    parameter int AF_THRESH = 6
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 w_en,
    input  logic                 full,
    input  logic [PTR_WIDTH:0]   b_wptr,
    input  logic [PTR_WIDTH:0]   g_rptr_sync,
    input  logic                 clr_stats,
    output logic [PTR_WIDTH:0]   wlevel,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   hwm,
    output logic                 ovf_sticky,
    output logic [7:0]           ovf_cnt,
    output logic                 level_err
);

    localparam int                PW      = PTR_WIDTH + 1;
    localparam int                DEPTH   = 1 << PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] DEPTH_V = PW'(DEPTH);
    localparam logic [PTR_WIDTH:0] AF_V    = PW'(AF_THRESH);

    logic [PTR_WIDTH:0] r_wp_q;
    logic [PTR_WIDTH:0] r_rb_q;
    logic [PTR_WIDTH:0] r_wlevel;
    logic               r_almost_full;
    logic [PTR_WIDTH:0] r_hwm;
    logic               r_ovf_sticky;
    logic [7:0]         r_ovf_cnt;
    logic               r_level_err;

    logic [PTR_WIDTH:0] w_rb_bin;
    logic [PTR_WIDTH:0] w_diff;
    logic               w_over;
    logic               w_ovf_evt;

    // Binary bit i is the XOR of all Gray bits from the MSB down to i.
    always_comb begin
        w_rb_bin = '0;
        for (int i = 0; i < PW; i++) begin
            w_rb_bin[i] = ^(g_rptr_sync >> i);
        end
    end

    // Modular subtraction covers pointer wrap with no MSB special-casing.
    assign w_diff    = r_wp_q - r_rb_q;
    assign w_over    = (w_diff > DEPTH_V);
    assign w_ovf_evt = w_en & full;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_wp_q        <= '0;
            r_rb_q        <= '0;
            r_wlevel      <= '0;
            r_almost_full <= 1'b0;
            r_hwm         <= '0;
            r_ovf_sticky  <= 1'b0;
            r_ovf_cnt     <= '0;
            r_level_err   <= 1'b0;
        end else begin
            r_wp_q <= b_wptr;
            r_rb_q <= w_rb_bin;

            // An impossible difference is clamped to full so throttling stays safe.
            if (w_over) begin
                r_wlevel      <= DEPTH_V;
                r_almost_full <= 1'b1;
            end else begin
                r_wlevel      <= w_diff;
                r_almost_full <= (w_diff >= AF_V);
            end

            if (clr_stats) begin
                r_hwm        <= r_wlevel;
                r_ovf_sticky <= 1'b0;
                r_ovf_cnt    <= '0;
                r_level_err  <= 1'b0;
            end else begin
                if (r_wlevel > r_hwm) begin
                    r_hwm <= r_wlevel;
                end
                if (w_over) begin
                    r_level_err <= 1'b1;
                end
                if (w_ovf_evt) begin
                    r_ovf_sticky <= 1'b1;
                    if (r_ovf_cnt != 8'hFF) begin
                        r_ovf_cnt <= r_ovf_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign wlevel      = r_wlevel;
    assign almost_full = r_almost_full;
    assign hwm         = r_hwm;
    assign ovf_sticky  = r_ovf_sticky;
    assign ovf_cnt     = r_ovf_cnt;
    assign level_err   = r_level_err;

endmodule
